timing_control_team1: RTL and testbench
=======================================

Name: timing_control_team1

Overview:
- Timing and instruction-decode front end of the basic computer.
- Contains the 4-bit sequence counter (SC), one-hot timing outputs T, the instruction register (IR), the 3-to-8 opcode decoder (D), the indirect flip-flop (I), the interrupt flip-flop (R) and the run flip-flop (S).
- Drives the T/D/I/R inputs of the memory control logic (MemoryC_team1).
- Captures the memory read word into IR during fetch.

Parameters:
- n, 16, memory/IR word width.
- SC_W, 4, sequence counter width; T width is 2**SC_W (16). Not overridden.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- mem_data  input  n  data word from memory out_MEM, captured into IR
- sc_clr  input  1  control-unit request: clear SC at next edge
- ien  input  1  interrupt enable flip-flop value
- fgi  input  1  input flag
- fgo  input  1  output flag
- halt  input  1  clears S (HLT instruction)
- start  input  1  sets S
- T  output  16  one-hot timing signals T0..T15
- D  output  8  decoded opcode D0..D7
- I  output  1  indirect bit
- R  output  1  interrupt cycle flag
- sc  output  4  current SC value (debug/verification)
- ir  output  n  instruction register
- running  output  1  S flip-flop

Behaviour:
- All registers update only on posedge clk. rst_n is sampled synchronously and has highest priority.
- Reset values:
  - sc=0, ir=0, I=0, R=0, running=1.
  - Outputs therefore show T=16'h0001 and D=8'h01.
- T is combinational: T = running ? (1 << sc) : 16'h0000.
  - When stopped, every T bit is 0, so no memory strobe can fire.
- D is combinational: D = 1 << ir[14:12]. Exactly one D bit is always high.
- SC next-state priority, highest first:
  1. rst_n=0 -> 0.
  2. Stopped (running=0 and no start) -> hold 0.
  3. halt=1 -> 0, and running becomes 0 at the same edge.
  4. sc_clr=1, or R&T2 -> 0.
  5. Otherwise sc+1, wrapping 15 -> 0 with no flag.
- S (running) flip-flop:
  - halt sets running=0 at the edge.
  - start sets running=1 with SC=0, so T0 appears in the following cycle.
  - halt and start together -> halt wins.
- IR load: at the edge ending a cycle with ~R & T1, ir <= mem_data. The memory is read at ~R&T1, so mem_data is valid during that cycle. Otherwise IR holds.
- I load: at the edge ending a cycle with ~R & T2, I <= ir[15]. Otherwise I holds.
- Latency:
  - IR is valid from T2.
  - D is valid from T2.
  - I is valid from T3.
- R flip-flop:
  - Set at an edge when running & ~T0 & ~T1 & ~T2 & ien & (fgi|fgo).
  - Cleared at the edge ending R&T2, together with SC clearing to 0.
  - If the set and clear conditions coincide, clear wins; the set condition cannot occur at T2 anyway.
  - While R=1, T1 produces no IR load and T2 produces no I load. ir and I hold their pre-interrupt values.
- R persists across sc_clr. The interrupt cycle begins at the next T0.
- halt while R=1: R holds its value. Stopped state still forces T=0.
- Reset mid-instruction: all state returns to reset values at that edge. T0 is asserted in the next cycle.
- Overlap: sc_clr asserted together with an IR-load or I-load cycle still performs the load.
- Block contains no combinational path from mem_data to any output except through ir.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release -> T=0001, sc=0, D=01, I=0, R=0, running=1. Then T walks 0002, 0004, ... one bit per cycle.
- Fetch/decode: present mem_data=16'h7800 during T1 -> at T2 ir=7800, D=80 (D7). I=0 from T3. Repeat with 16'hA123 -> D=04 (D2), I=1 from T3.
- Wrap and clear: no sc_clr for 16 cycles -> T reaches 8000 then returns to 0001. Assert sc_clr during T4 -> next cycle T=0001.
- Interrupt: ien=1, fgi=1 during T5 -> R=1 next edge. Assert sc_clr at T6 -> R cycle runs T0, T1 (ir unchanged despite mem_data=FFFF), T2. Next cycle R=0, T=0001.
- Halt/start: halt at T3 -> next cycle T=0000, running=0, sc=0 and held for 5 cycles. Assert start -> following cycle T=0001, running=1. halt and start together -> stays stopped.
- Reset mid-operation: rst_n=0 at T7 with R=1 and ir=A123 -> next cycle all reset values, T=0001.

Source files
------------

// File: rtl/timing_control_team1.sv
`default_nettype none
// ============================================================================
// Module   : timing_control_team1
// Purpose  : Timing and instruction-decode front end of the basic computer.
//            Holds the sequence counter (SC), the instruction register (IR),
//            the indirect (I), interrupt (R) and run (S) flip-flops. It also
//            decodes the one-hot timing signals T and the opcode lines D.
// Ports    :
//   clk      in   system clock, rising-edge
//   rst_n    in   synchronous active-low reset
//   mem_data in   [N-1:0] memory read word, captured into IR at ~R&T1
//   sc_clr   in   clear SC at the next edge
//   ien      in   interrupt enable flip-flop value
//   fgi      in   input flag
//   fgo      in   output flag
//   halt     in   clear S (HLT)
//   start    in   set S
//   T        out  [2**SC_W-1:0] one-hot timing, all zero while stopped
//   D        out  [7:0] decoded opcode ir[14:12]
//   I        out  indirect bit
//   R        out  interrupt cycle flag
//   sc       out  [SC_W-1:0] current sequence count
//   ir       out  [N-1:0] instruction register
//   running  out  S flip-flop
// Revision : 1.0 - initial release
// ============================================================================
module timing_control_team1 #(
    parameter int N    = 16,
    parameter int SC_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         mem_data,
    input  logic                 sc_clr,
    input  logic                 ien,
    input  logic                 fgi,
    input  logic                 fgo,
    input  logic                 halt,
    input  logic                 start,
    output logic [2**SC_W-1:0]   T,
    output logic [7:0]           D,
    output logic                 I,
    output logic                 R,
    output logic [SC_W-1:0]      sc,
    output logic [N-1:0]         ir,
    output logic                 running
);

    localparam int C_TW = 2**SC_W;

    logic [SC_W-1:0] r_sc;
    logic [N-1:0]    r_ir;
    logic            r_i;
    logic            r_r;
    logic            r_s;

    logic [C_TW-1:0] w_t;
    logic            w_ir_load;
    logic            w_i_load;
    logic            w_r_clear;
    logic            w_r_set;

    // Timing is gated by S so that no memory strobe can fire while stopped.
    assign w_t = r_s ? (C_TW'(1) << r_sc) : '0;

    assign w_ir_load = ~r_r & w_t[1];
    assign w_i_load  = ~r_r & w_t[2];
    assign w_r_clear =  r_r & w_t[2];
    // Interrupt requests are only honoured outside the fetch/decode window.
    assign w_r_set   = r_s & ~w_t[0] & ~w_t[1] & ~w_t[2] & ien & (fgi | fgo);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sc <= '0;
            r_ir <= '0;
            r_i  <= 1'b0;
            r_r  <= 1'b0;
            r_s  <= 1'b1;
        end else begin
            // A stopped machine keeps SC at 0, including on the start edge,
            // so the first active cycle after start is always T0.
            if (!r_s || halt) begin
                r_sc <= '0;
            end else if (sc_clr || w_r_clear) begin
                r_sc <= '0;
            end else begin
                r_sc <= r_sc + 1'b1;
            end

            if (halt) begin
                r_s <= 1'b0;
            end else if (start) begin
                r_s <= 1'b1;
            end

            // Loads are independent of sc_clr so a clear on a load cycle
            // does not lose the fetched word or the indirect bit.
            if (w_ir_load) begin
                r_ir <= mem_data;
            end

            if (w_i_load) begin
                r_i <= r_ir[N-1];
            end

            if (w_r_clear) begin
                r_r <= 1'b0;
            end else if (w_r_set) begin
                r_r <= 1'b1;
            end
        end
    end

    assign T       = w_t;
    assign D       = 8'(1) << r_ir[14:12];
    assign I       = r_i;
    assign R       = r_r;
    assign sc      = r_sc;
    assign ir      = r_ir;
    assign running = r_s;

endmodule
`default_nettype wire

// File: tb/tb_timing_control_team1.sv
`default_nettype none
// ============================================================================
// Module   : tb_timing_control_team1
// Purpose  : Directed self-checking bench for timing_control_team1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timing_control_team1;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_data;
    logic        sc_clr;
    logic        ien;
    logic        fgi;
    logic        fgo;
    logic        halt;
    logic        start;
    logic [15:0] T;
    logic [7:0]  D;
    logic        I;
    logic        R;
    logic [3:0]  sc;
    logic [15:0] ir;
    logic        running;

    int n_checks;
    int n_pass;

    timing_control_team1 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_data (mem_data),
        .sc_clr   (sc_clr),
        .ien      (ien),
        .fgi      (fgi),
        .fgo      (fgo),
        .halt     (halt),
        .start    (start),
        .T        (T),
        .D        (D),
        .I        (I),
        .R        (R),
        .sc       (sc),
        .ir       (ir),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one edge; sampling and driving happen 1ns after it.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        mem_data = 16'h0000;
        sc_clr   = 1'b0;
        ien      = 1'b0;
        fgi      = 1'b0;
        fgo      = 1'b0;
        halt     = 1'b0;
        start    = 1'b0;

        // ---------------- reset ----------------
        tick(2);
        rst_n = 1'b1;
        check("rst_T",   T,       16'h0001);
        check("rst_sc",  sc,      4'd0);
        check("rst_D",   D,       8'h01);
        check("rst_I",   I,       1'b0);
        check("rst_R",   R,       1'b0);
        check("rst_run", running, 1'b1);
        check("rst_ir",  ir,      16'h0000);
        tick();
        check("walk_T1", T, 16'h0002);
        tick();
        check("walk_T2", T, 16'h0004);

        // ---------------- fetch/decode 7800 ----------------
        sc_clr = 1'b1;
        tick();
        check("clr_T0", T, 16'h0001);
        sc_clr   = 1'b0;
        mem_data = 16'h7800;
        tick(2);
        check("f1_T2", T,  16'h0004);
        check("f1_ir", ir, 16'h7800);
        check("f1_D",  D,  8'h80);
        tick();
        check("f1_I",  I,  1'b0);

        // ---------------- fetch/decode A123 ----------------
        sc_clr = 1'b1;
        tick();
        sc_clr   = 1'b0;
        mem_data = 16'hA123;
        tick(2);
        check("f2_ir",   ir, 16'hA123);
        check("f2_D",    D,  8'h04);
        check("f2_I_T2", I,  1'b0);
        tick();
        check("f2_I_T3", I,  1'b1);

        // ---------------- wrap and clear ----------------
        tick(12);
        check("wrap_T15", T,  16'h8000);
        check("wrap_sc",  sc, 4'd15);
        tick();
        check("wrap_T0",  T,  16'h0001);
        tick(4);
        check("T4", T, 16'h0010);
        sc_clr = 1'b1;
        tick();
        check("clrT4_T0", T, 16'h0001);
        sc_clr = 1'b0;

        // ---------------- interrupt ----------------
        tick(5);
        check("int_T5", T, 16'h0020);
        check("int_R0", R, 1'b0);
        ien = 1'b1;
        fgi = 1'b1;
        tick();
        check("int_Rset", R, 1'b1);
        ien    = 1'b0;
        fgi    = 1'b0;
        sc_clr = 1'b1;
        tick();
        check("int_T0", T, 16'h0001);
        check("int_R_T0", R, 1'b1);
        sc_clr   = 1'b0;
        mem_data = 16'hFFFF;
        tick(2);
        check("int_T2",   T,  16'h0004);
        check("int_ir",   ir, 16'hA123);
        check("int_R_T2", R,  1'b1);
        tick();
        check("int_Rclr", R,  1'b0);
        check("int_end_T", T, 16'h0001);
        check("int_I_hold", I, 1'b1);
        mem_data = 16'hA123;

        // ---------------- halt / start ----------------
        tick(3);
        check("h_T3", T, 16'h0008);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("h_T",   T,       16'h0000);
        check("h_run", running, 1'b0);
        check("h_sc",  sc,      4'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_T",  T,  16'h0000);
            check("hold_sc", sc, 4'd0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s_T",   T,       16'h0001);
        check("s_run", running, 1'b1);
        halt  = 1'b1;
        start = 1'b1;
        tick();
        check("hs_run", running, 1'b0);
        check("hs_T",   T,       16'h0000);
        tick();
        check("hs_run2", running, 1'b0);
        halt = 1'b0;
        tick();
        start = 1'b0;
        check("s2_run", running, 1'b1);
        check("s2_T",   T,       16'h0001);

        // ---------------- reset mid-operation ----------------
        tick(5);
        check("m_T5", T, 16'h0020);
        ien = 1'b1;
        fgo = 1'b1;
        tick();
        ien = 1'b0;
        fgo = 1'b0;
        tick();
        check("m_T7", T,  16'h0080);
        check("m_R",  R,  1'b1);
        check("m_ir", ir, 16'hA123);
        rst_n = 1'b0;
        tick();
        check("mr_T",   T,       16'h0001);
        check("mr_sc",  sc,      4'd0);
        check("mr_ir",  ir,      16'h0000);
        check("mr_R",   R,       1'b0);
        check("mr_I",   I,       1'b0);
        check("mr_run", running, 1'b1);
        check("mr_D",   D,       8'h01);
        rst_n = 1'b1;
        tick();
        check("mr_T1", T, 16'h0002);

        // ---------------- sc_clr overlapping IR load ----------------
        mem_data = 16'h7800;
        sc_clr   = 1'b1;
        tick();
        sc_clr = 1'b0;
        check("ov_T",  T,  16'h0001);
        check("ov_ir", ir, 16'h7800);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
